// File: rtl/conv_row_mac.sv
// conv_row_mac -- TAPS-wide 1-D convolution row MAC with multi-channel
// accumulation, bias and shift-and-saturate requantisation.
//
// Sits between the pixel/weight memory readers and the output-feature-map
// writer. Three registered stages: per-tap products, tap sum, accumulate.
//
// Optional build macro: CONV_ROW_RELU_EN -- when defined, negative results on
// a last beat are output as zero (Y1 and y_q); the accumulator is unaffected.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid            input beat valid
//   first / last        channel framing of the output pixel
//   i, stride_plus_prov output pixel index and offset (row-mask index)
//   matrix, matrix2     feature-map width and width*height
//   up_perm, down_perm  top/bottom row masking enables
//   edge_left/right     zero tap 0 / tap TAPS-1
//   p_flat, w_flat      packed signed pixels/weights, tap k at [k*W +: W]
//   bias                signed bias, added on first beats
//   shift               arithmetic right shift for y_q
//   out_valid           single-cycle result strobe
//   Y1                  full-precision signed result
//   y_q                 saturated requantised result
module conv_row_mac #(
   parameter int TAPS             = 3,
   parameter int SIZE             = 8,
   parameter int SIZE_weights     = 8,
   parameter int SIZE_address_pix = 18,
   parameter int ACC_W            = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   input  logic                           first,
   input  logic                           last,
   input  logic [14:0]                    i,
   input  logic [SIZE_address_pix-1:0]    stride_plus_prov,
   input  logic [7:0]                     matrix,
   input  logic [14:0]                    matrix2,
   input  logic                           up_perm,
   input  logic                           down_perm,
   input  logic                           edge_left,
   input  logic                           edge_right,
   input  logic [TAPS*SIZE-1:0]           p_flat,
   input  logic [TAPS*SIZE_weights-1:0]   w_flat,
   input  logic [ACC_W-1:0]               bias,
   input  logic [4:0]                     shift,
   output logic                           out_valid,
   output logic [ACC_W-1:0]               Y1,
   output logic [SIZE-1:0]                y_q
);

   localparam int PW = SIZE + SIZE_weights;
   // Index width with headroom so idx and idx+matrix never wrap.
   localparam int IW = ((SIZE_address_pix > 15) ? SIZE_address_pix : 15) + 2;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (SIZE - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   // ---------------- stage 0: masks and products (combinational) ----------
   logic [IW-1:0]          idx;
   logic [IW-1:0]          mat_w;
   logic                   up;
   logic                   down;
   logic signed [PW-1:0]   prod_d [TAPS];

   always_comb begin
      idx   = IW'(i) + IW'(stride_plus_prov);
      mat_w = IW'(matrix);
      // idx <= matrix-1 written as idx < matrix so matrix=0 cannot underflow.
      up    = up_perm && (idx < mat_w);
      // idx >= matrix2-matrix rearranged to avoid a negative bound.
      down  = down_perm && ((idx + mat_w) >= IW'(matrix2));
      for (int k = 0; k < TAPS; k++) begin
         prod_d[k] = PW'($signed(p_flat[k*SIZE +: SIZE])) *
                     PW'($signed(w_flat[k*SIZE_weights +: SIZE_weights]));
         if (up || down || (k == 0 && edge_left) || (k == TAPS - 1 && edge_right))
            prod_d[k] = '0;
      end
   end

   // ---------------- stage 1 ----------------------------------------------
   logic                   v1_q, f1_q, l1_q;
   logic [ACC_W-1:0]       bias1_q;
   logic [4:0]             sh1_q;
   logic signed [PW-1:0]   prod_q [TAPS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q    <= 1'b0;
         f1_q    <= 1'b0;
         l1_q    <= 1'b0;
         bias1_q <= '0;
         sh1_q   <= '0;
         for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
      end else begin
         v1_q    <= in_valid;
         f1_q    <= first;
         l1_q    <= last;
         bias1_q <= bias;
         sh1_q   <= shift;
         for (int k = 0; k < TAPS; k++) prod_q[k] <= prod_d[k];
      end
   end

   // ---------------- stage 2 ----------------------------------------------
   logic signed [ACC_W-1:0] sum_d;
   logic signed [ACC_W-1:0] sum_q;
   logic                    v2_q, f2_q, l2_q;
   logic [ACC_W-1:0]        bias2_q;
   logic [4:0]              sh2_q;

   always_comb begin
      sum_d = '0;
      for (int k = 0; k < TAPS; k++) sum_d = sum_d + ACC_W'(prod_q[k]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_q    <= 1'b0;
         f2_q    <= 1'b0;
         l2_q    <= 1'b0;
         bias2_q <= '0;
         sh2_q   <= '0;
         sum_q   <= '0;
      end else begin
         v2_q    <= v1_q;
         f2_q    <= f1_q;
         l2_q    <= l1_q;
         bias2_q <= bias1_q;
         sh2_q   <= sh1_q;
         sum_q   <= sum_d;
      end
   end

   // ---------------- stage 3: accumulate and requantise -------------------
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] shifted;
   logic                    ov_q, ov_d;
   logic [ACC_W-1:0]        y1_q, y1_d;
   logic [SIZE-1:0]         yq_q, yq_d;

   always_comb begin
      acc_d = acc_q;
      ov_d  = 1'b0;
      y1_d  = y1_q;
      yq_d  = yq_q;
      if (v2_q) begin
         acc_d = (f2_q ? $signed(bias2_q) : acc_q) + sum_q;
      end
      shifted = acc_d >>> sh2_q;
      if (v2_q && l2_q) begin
         ov_d = 1'b1;
         y1_d = acc_d;
         if (shifted > SAT_MAX)      yq_d = SAT_MAX[SIZE-1:0];
         else if (shifted < SAT_MIN) yq_d = SAT_MIN[SIZE-1:0];
         else                        yq_d = shifted[SIZE-1:0];
`ifdef CONV_ROW_RELU_EN
         if (acc_d[ACC_W-1]) begin
            y1_d = '0;
            yq_d = '0;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         ov_q  <= 1'b0;
         y1_q  <= '0;
         yq_q  <= '0;
      end else begin
         acc_q <= acc_d;
         ov_q  <= ov_d;
         y1_q  <= y1_d;
         yq_q  <= yq_d;
      end
   end

   assign out_valid = ov_q;
   assign Y1        = y1_q;
   assign y_q       = yq_q;

endmodule
